// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one dual-clock FIFO write port among NREQ requesters.
// Grants bursts of up to BURST beats; each pushed beat is tagged {id, payload} and counted.
//
// state | meaning
// IDLE  | no grant held; pick next valid requester after rr_ptr
// GRANT | GRANT_ID owns the write port until burst end, valid drop or disable
module fifo_wr_arb #(
  parameter int DSIZE = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int BURST = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  ENABLE,
  input  logic [NREQ-1:0]       REQ_VALID,
  input  logic [NREQ*DSIZE-1:0] REQ_DATA,
  output logic [NREQ-1:0]       REQ_READY,
  output logic [IDW+DSIZE-1:0]  FIFO_WDATA,
  output logic                  FIFO_WINC,
  input  logic                  FIFO_WFULL,
  output logic [IDW-1:0]        GRANT_ID,
  output logic                  BUSY,
  output logic [15:0]           BEAT_CNT
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  grant_id_q, grant_id_d;
  logic [3:0]      burst_q, burst_d;
  logic [15:0]     beat_cnt_q, beat_cnt_d;

  logic             g_valid;
  logic [DSIZE-1:0] g_data;
  logic             pick_found;
  logic [IDW-1:0]   pick_id;
  logic             accept;

  always_comb begin
    g_valid = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id_q == IDW'(i)) begin
        g_valid = REQ_VALID[i];
        g_data  = REQ_DATA[i*DSIZE +: DSIZE];
      end
    end
  end

  // Two passes: indices above rr_ptr first, then wrap around from 0.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!pick_found && REQ_VALID[i] && (IDW'(i) > rr_ptr_q)) begin
        pick_found = 1'b1;
        pick_id    = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!pick_found && REQ_VALID[i] && (IDW'(i) <= rr_ptr_q)) begin
        pick_found = 1'b1;
        pick_id    = IDW'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    burst_d    = burst_q;
    beat_cnt_d = beat_cnt_q;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ENABLE && pick_found) begin
          grant_id_d = pick_id;
          burst_d    = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        accept = g_valid && !FIFO_WFULL;
        if (accept) begin
          burst_d    = burst_q + 4'd1;
          beat_cnt_d = beat_cnt_q + 16'd1;
        end
        // A stalled requester keeps the grant; only these three release it.
        if (!ENABLE || !g_valid || (accept && (burst_d == 4'(BURST)))) begin
          state_d  = IDLE;
          rr_ptr_d = grant_id_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      rr_ptr_q   <= IDW'(NREQ - 1);
      grant_id_q <= '0;
      burst_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      burst_q    <= burst_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    REQ_READY = '0;
    for (int i = 0; i < NREQ; i++) begin
      if ((state_q == GRANT) && (grant_id_q == IDW'(i))) REQ_READY[i] = !FIFO_WFULL;
    end
  end

  assign FIFO_WINC  = accept;
  assign FIFO_WDATA = {grant_id_q, g_data};
  assign GRANT_ID   = grant_id_q;
  assign BUSY       = (state_q == GRANT);
  assign BEAT_CNT   = beat_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Scoreboard bench for fifo_wr_arb: per-requester expected-beat queues filled by the
// stimulus driver, popped by an independent monitor that also tracks round-robin fairness.
module tb_fifo_wr_arb;
  localparam int DSIZE = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int BURST = 4;
  localparam int WBURST = 15;
  localparam int W = IDW + DSIZE;

  logic                  CLK = 1'b0;
  logic                  RST_N = 1'b0;
  logic                  ENABLE = 1'b0;
  logic                  FIFO_WFULL = 1'b0;
  logic [NREQ-1:0]       REQ_VALID = '0;
  logic [NREQ*DSIZE-1:0] REQ_DATA = '0;
  logic [NREQ-1:0]       REQ_READY;
  logic [W-1:0]          FIFO_WDATA;
  logic                  FIFO_WINC;
  logic [IDW-1:0]        GRANT_ID;
  logic                  BUSY;
  logic [15:0]           BEAT_CNT;

  logic                  w_rst_n = 1'b0;
  logic                  w_en = 1'b1;
  logic                  w_full = 1'b0;
  logic [NREQ-1:0]       w_valid = '1;
  logic [NREQ*DSIZE-1:0] w_data = '0;
  logic [NREQ-1:0]       w_ready;
  logic [W-1:0]          w_wdata;
  logic                  w_winc;
  logic [IDW-1:0]        w_gid;
  logic                  w_busy;
  logic [15:0]           w_beat_cnt;

  fifo_wr_arb #(.DSIZE(DSIZE), .NREQ(NREQ), .IDW(IDW), .BURST(BURST)) dut (
    .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA),
    .REQ_READY(REQ_READY), .FIFO_WDATA(FIFO_WDATA), .FIFO_WINC(FIFO_WINC),
    .FIFO_WFULL(FIFO_WFULL), .GRANT_ID(GRANT_ID), .BUSY(BUSY), .BEAT_CNT(BEAT_CNT));

  // Second instance with the largest burst, used only to run BEAT_CNT through its wrap.
  fifo_wr_arb #(.DSIZE(DSIZE), .NREQ(NREQ), .IDW(IDW), .BURST(WBURST)) u_wrap (
    .CLK(CLK), .RST_N(w_rst_n), .ENABLE(w_en), .REQ_VALID(w_valid), .REQ_DATA(w_data),
    .REQ_READY(w_ready), .FIFO_WDATA(w_wdata), .FIFO_WINC(w_winc),
    .FIFO_WFULL(w_full), .GRANT_ID(w_gid), .BUSY(w_busy), .BEAT_CNT(w_beat_cnt));

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Requester sources
  int               src_left [NREQ];
  bit               src_pres [NREQ];
  logic [DSIZE-1:0] src_cur  [NREQ];
  logic [DSIZE-1:0] src_next [NREQ];
  bit               acc      [NREQ];
  logic [W-1:0]     exp_q    [NREQ][$];

  always @(negedge CLK) begin
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) src_pres[i] = 1'b0;
      if (!src_pres[i] && src_left[i] > 0) begin
        src_pres[i] = 1'b1;
        src_cur[i]  = src_next[i];
        src_next[i] = src_next[i] + 8'd1;
        src_left[i] = src_left[i] - 1;
        exp_q[i].push_back({IDW'(i), src_cur[i]});
      end
      REQ_VALID[i] = src_pres[i];
      REQ_DATA[i*DSIZE +: DSIZE] = src_cur[i];
    end
  end

  // Monitor / reference model
  int              cyc = 0;
  int              mon_beats = 0;
  int              model_ptr = NREQ - 1;
  int              last_gid = 0;
  int              cur_id = 0;
  int              cur_beats = 0;
  logic [15:0]     model_cnt = '0;
  bit              prev_ok = 0, prev_busy = 0, prev_en = 0, prev_done = 0;
  logic [NREQ-1:0] prev_valid = '0;
  int              grant_log[$];
  int              burst_log[$];

  always @(negedge CLK) begin
    int eg;
    bit leave;
    logic [NREQ-1:0] exp_rdy;
    logic [W-1:0] want;
    #3;
    cyc++;
    for (int i = 0; i < NREQ; i++) acc[i] = REQ_VALID[i] & REQ_READY[i];
    if (!RST_N) begin
      model_ptr = NREQ - 1; model_cnt = '0; last_gid = 0; cur_id = 0; cur_beats = 0;
      prev_ok = 0; prev_busy = 0; prev_done = 0;
    end else begin
      if (prev_ok) begin
        if (!prev_busy) begin
          check("grant_start", BUSY, prev_en && (prev_valid != '0));
          if (BUSY) begin
            eg = -1;
            for (int k = 1; k <= NREQ; k++)
              if (eg < 0 && prev_valid[(model_ptr + k) % NREQ]) eg = (model_ptr + k) % NREQ;
            check("grant_id", GRANT_ID, eg);
            grant_log.push_back(eg);
            cur_id = eg;
            cur_beats = 0;
          end else begin
            check("grant_id_hold", GRANT_ID, last_gid);
          end
        end else begin
          leave = prev_done || !prev_en || !prev_valid[cur_id];
          check("busy_in_grant", BUSY, !leave);
          if (BUSY) check("grant_id_stable", GRANT_ID, cur_id);
          else begin
            model_ptr = cur_id;
            last_gid = cur_id;
            burst_log.push_back(cur_beats);
          end
        end
      end
      check("beat_cnt", BEAT_CNT, model_cnt);
      exp_rdy = '0;
      if (BUSY && !FIFO_WFULL) exp_rdy[cur_id] = 1'b1;
      check("req_ready", REQ_READY, exp_rdy);
      check("winc", FIFO_WINC, (REQ_VALID & REQ_READY) != '0);
      prev_done = 0;
      if (FIFO_WINC) begin
        check("tag", FIFO_WDATA[W-1:DSIZE], cur_id);
        checks++;
        if (exp_q[cur_id].size() == 0) begin
          errors++;
          $display("FAIL push_unexpected: requester %0d pushed %0h, expected nothing outstanding", cur_id, FIFO_WDATA);
        end else begin
          want = exp_q[cur_id].pop_front();
          check("push_data", FIFO_WDATA, want);
        end
        mon_beats++;
        model_cnt = model_cnt + 16'd1;
        cur_beats++;
        check("burst_len", cur_beats <= BURST, 1'b1);
        prev_done = (cur_beats == BURST);
      end
      prev_busy = BUSY; prev_en = ENABLE; prev_valid = REQ_VALID; prev_ok = 1;
    end
  end

  task automatic reset_all(input int ld[NREQ], input logic en);
    @(negedge CLK); #1;
    RST_N = 1'b0; ENABLE = en; FIFO_WFULL = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      src_pres[i] = 0; acc[i] = 0; exp_q[i].delete(); src_left[i] = ld[i];
    end
    repeat (2) @(negedge CLK);
    #1 RST_N = 1'b1;
    grant_log.delete(); burst_log.delete(); mon_beats = 0;
  endtask

  task automatic wait_beats(input int n, input string name);
    int t = 0;
    while (mon_beats < n && t < 1000) begin @(negedge CLK); #4; t++; end
    checks++;
    if (mon_beats < n) begin
      errors++;
      $display("FAIL %s_timeout: beats %0d, needed %0d", name, mon_beats, n);
    end
  endtask

  // BEAT_CNT wrap on the second instance
  int w_pushes = 0;
  bit wrap_done = 0;
  always @(negedge CLK) begin
    #3;
    if (w_rst_n && w_winc) w_pushes++;
  end

  initial begin
    int t;
    #12 w_rst_n = 1'b1;
    t = 0;
    while (w_pushes < 65534 && t < 80000) begin @(negedge CLK); #4; t++; end
    @(negedge CLK); #4;
    check("wrap_fffe", w_beat_cnt, 16'hFFFE);
    t = 0;
    while (w_pushes < 65537 && t < 100) begin @(negedge CLK); #4; t++; end
    @(negedge CLK); #4;
    check("wrap_0001", w_beat_cnt, 16'h0001);
    wrap_done = 1;
  end

  initial begin
    int ld[NREQ];
    int exp1[5] = '{0, 1, 2, 3, 0};
    int rel_cyc;
    int t;
    bit drained;
    for (int i = 0; i < NREQ; i++) begin
      src_left[i] = 0; src_pres[i] = 0; src_cur[i] = '0; acc[i] = 0;
      src_next[i] = 8'(i * 64);
    end

    // Reset values
    repeat (2) @(negedge CLK);
    #4;
    check("rst_busy", BUSY, 1'b0);
    check("rst_grant_id", GRANT_ID, '0);
    check("rst_beat_cnt", BEAT_CNT, 16'd0);

    // All four continuously valid: order 0,1,2,3,0, 4 beats each plus one idle cycle
    ld = '{8, 8, 8, 8};
    reset_all(ld, 1'b1);
    rel_cyc = cyc;
    wait_beats(20, "t1");
    check("t1_cycles", cyc - rel_cyc, 25);
    @(negedge CLK); #4;
    check("t1_beat_cnt", BEAT_CNT, 16'd20);
    check("t1_glog_size", grant_log.size() >= 5, 1'b1);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) check("t1_grant_order", grant_log[i], exp1[i]);
    for (int i = 0; i < 5 && i < burst_log.size(); i++) check("t1_burst_len", burst_log[i], BURST);

    // Requester 2 alone for 3 beats, then 1 and 3 together: 3 wins
    ld = '{0, 0, 3, 0};
    reset_all(ld, 1'b1);
    wait_beats(3, "t2a");
    repeat (3) @(negedge CLK);
    src_left[1] = 2; src_left[3] = 2;
    wait_beats(7, "t2b");
    check("t2_glog_size", grant_log.size(), 3);
    if (grant_log.size() >= 3) begin
      check("t2_grant0", grant_log[0], 2);
      check("t2_grant1", grant_log[1], 3);
      check("t2_grant2", grant_log[2], 1);
    end
    if (burst_log.size() >= 1) check("t2_burst0", burst_log[0], 3);

    // FIFO full for 5 cycles mid-burst of requester 1
    ld = '{0, 6, 0, 0};
    reset_all(ld, 1'b1);
    wait_beats(2, "t3a");
    @(negedge CLK);
    FIFO_WFULL = 1'b1;
    repeat (5) begin
      #4;
      check("t3_ready_stall", REQ_READY[1], 1'b0);
      check("t3_winc_stall", FIFO_WINC, 1'b0);
      check("t3_busy_stall", BUSY, 1'b1);
      @(negedge CLK);
    end
    FIFO_WFULL = 1'b0;
    check("t3_frozen", mon_beats, 2);
    wait_beats(6, "t3b");
    check("t3_glog_size", grant_log.size(), 2);
    if (burst_log.size() >= 1) check("t3_burst0", burst_log[0], 4);
    else check("t3_burst_log_size", burst_log.size(), 1);

    // ENABLE falls while beat 2 of requester 0 is accepted
    ld = '{6, 3, 3, 3};
    reset_all(ld, 1'b1);
    wait_beats(1, "t4a");
    @(negedge CLK);
    ENABLE = 1'b0;
    repeat (10) begin
      @(negedge CLK); #4;
      check("t4_idle", BUSY, 1'b0);
    end
    check("t4_beats", mon_beats, 2);
    @(negedge CLK);
    ENABLE = 1'b1;
    wait_beats(5, "t4b");
    check("t4_glog_size", grant_log.size() >= 2, 1'b1);
    if (grant_log.size() >= 2) begin
      check("t4_grant0", grant_log[0], 0);
      check("t4_grant1", grant_log[1], 1);
    end
    if (burst_log.size() >= 1) check("t4_burst0", burst_log[0], 2);

    // Asynchronous reset mid-burst
    ld = '{4, 4, 4, 4};
    reset_all(ld, 1'b1);
    wait_beats(1, "t5a");
    @(negedge CLK); #1;
    check("t5_winc_pre", FIFO_WINC, 1'b1);
    check("t5_ready_pre", REQ_READY, 4'b0001);
    RST_N = 1'b0;
    #1;
    check("t5_winc_rst", FIFO_WINC, 1'b0);
    check("t5_ready_rst", REQ_READY, '0);
    check("t5_busy_rst", BUSY, 1'b0);
    repeat (2) @(negedge CLK);
    #1 RST_N = 1'b1;
    grant_log.delete(); burst_log.delete(); mon_beats = 0;
    #3;
    check("t5_beat_cnt", BEAT_CNT, 16'd0);
    t = 0;
    while (grant_log.size() == 0 && t < 50) begin @(negedge CLK); #4; t++; end
    check("t5_glog_size", grant_log.size() >= 1, 1'b1);
    if (grant_log.size() >= 1) check("t5_first_grant", grant_log[0], 0);

    // Randomised traffic with random full and enable
    for (int c = 0; c < 1500; c++) begin
      @(negedge CLK);
      for (int i = 0; i < NREQ; i++)
        if (src_left[i] == 0 && $urandom_range(0, 9) == 0) src_left[i] = $urandom_range(1, 7);
      FIFO_WFULL = ($urandom_range(0, 4) == 0);
      ENABLE = ($urandom_range(0, 19) != 0);
    end
    @(negedge CLK);
    FIFO_WFULL = 1'b0;
    ENABLE = 1'b1;
    t = 0;
    drained = 0;
    while (!drained && t < 3000) begin
      @(negedge CLK); #4; t++;
      drained = 1;
      for (int i = 0; i < NREQ; i++)
        if (src_left[i] != 0 || exp_q[i].size() != 0) drained = 0;
    end
    for (int i = 0; i < NREQ; i++) check("rand_drain", exp_q[i].size(), 0);

    t = 0;
    while (!wrap_done && t < 90000) begin @(negedge CLK); t++; end
    check("wrap_finished", wrap_done, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
Name: fifo_wr_arb

Overview:
- Round-robin arbiter that shares the single write port of a dual-clock FIFO among NREQ requesters in the write-clock domain.
- Each requester has a valid/ready handshake and is granted bursts of up to BURST beats.
- Each accepted beat is tagged with the requester index, pushed as {ID, DATA}, and counted.
- Sits between the producer blocks (e.g. DMA / CPU-side writers) and the FIFO's WDATA/WINC/WFULL pins, on the FIFO's write clock.

Parameters:
- DSIZE, 8, payload width per requester.
- NREQ, 4, number of requesters; fixed 2..4.
- IDW, 2, tag width; must satisfy 2**IDW >= NREQ.
- BURST, 4, maximum beats per grant; 1..15.

Ports:
- CLK  in  1  write-side clock, same as the FIFO's WCLK.
- RST_N  in  1  asynchronous active-low reset.
- ENABLE  in  1  arbitration enable.
- REQ_VALID  in  NREQ  per-requester beat valid.
- REQ_DATA  in  NREQ*DSIZE  requester i occupies bits [i*DSIZE +: DSIZE].
- REQ_READY  out  NREQ  per-requester accept; a beat transfers when VALID & READY.
- FIFO_WDATA  out  IDW+DSIZE  {granted id, payload}.
- FIFO_WINC  out  1  FIFO push strobe.
- FIFO_WFULL  in  1  FIFO full flag; registered on CLK by the FIFO.
- GRANT_ID  out  IDW  current or last granted requester.
- BUSY  out  1  high in GRANT state.
- BEAT_CNT  out  16  total accepted beats; wraps.

Behaviour:
- Reset (asynchronous, RST_N low): state=IDLE, rr_ptr=NREQ-1, GRANT_ID=0, burst count=0, BEAT_CNT=0. REQ_READY=0, FIFO_WINC=0 and BUSY=0 take effect immediately, not on the next edge.
- FSM has two states: IDLE and GRANT.
- IDLE:
  - If ENABLE and any REQ_VALID: choose the first set bit searching rr_ptr+1, rr_ptr+2, … modulo NREQ.
  - Register it into GRANT_ID, clear burst count, go to GRANT.
  - Arbitration latency is one cycle; no beat is accepted in IDLE.
- GRANT, g = GRANT_ID:
  - REQ_READY[g] = !FIFO_WFULL; all other READY bits = 0. This is combinational from FIFO_WFULL.
  - FIFO_WINC = REQ_VALID[g] & !FIFO_WFULL.
  - FIFO_WDATA = {g, REQ_DATA[g]}. FIFO_WDATA is don't-care when FIFO_WINC=0 but is driven from g.
  - Each accepted beat increments burst count and BEAT_CNT (16-bit wrap, 0xFFFF -> 0x0000).
- Leave GRANT (go to IDLE, rr_ptr <= g) on the first of:
  - (a) accepted beat makes burst count == BURST;
  - (b) REQ_VALID[g]=0;
  - (c) ENABLE=0.
  - A beat accepted in the same cycle as (a) still counts.
  - A requester that is stalled by FIFO_WFULL keeps the grant; burst count does not advance.
- Starvation bound: a continuously valid requester waits at most (NREQ-1)*(BURST+1) accepted-or-stalled grant slots. With no stalls that is (NREQ-1)*(BURST+1) cycles plus 1.
- Single requester: after release it is re-granted through IDLE, so throughput is BURST beats per BURST+1 cycles.
- Simultaneous events:
  - FIFO_WFULL rising in the same cycle as the final burst beat: that beat was accepted (WFULL was low that cycle); normal release.
  - ENABLE falling while a beat is accepted: the beat completes, then IDLE.
- GRANT_ID holds its value in IDLE. BUSY = (state==GRANT).
- Unused tag codes (id >= NREQ) are never emitted.
- No data is stored inside the block; the payload passes through combinationally in the grant cycle.

Test Plan:
- Reset, then all four requesters valid continuously, WFULL=0, BURST=4: grant order 0,1,2,3,0. Each grant yields 4 beats followed by 1 IDLE cycle; tags 0..3 appear on FIFO_WDATA[IDW+DSIZE-1:DSIZE]; after 20 beats BEAT_CNT=20.
- Requester 2 alone valid with 3 beats, then drops: IDLE -> GRANT(2), 3 pushes, release on valid low, rr_ptr=2. A new request from requester 1 and requester 3 together grants 3 first.
- Hold FIFO_WFULL=1 for 5 cycles mid-burst of requester 1: READY[1]=0 and FIFO_WINC=0 throughout; burst count is frozen at its value. The burst resumes and completes exactly 4 beats total, with no duplicated or lost data (checked by an incrementing payload).
- Drop ENABLE during GRANT(0) after 2 beats: the next cycle is IDLE with no further grants while ENABLE=0. On re-enable, arbitration restarts at requester 1.
- Assert RST_N low mid-burst between clock edges: FIFO_WINC and REQ_READY fall immediately; after release BEAT_CNT=0 and the first grant goes to requester 0.
- Preload BEAT_CNT to 0xFFFE by pushing 65534 beats, then 3 more beats: BEAT_CNT reads 0x0001.
